// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   arb_state_t : FSM state encoding (IDLE = no tenure, GRANT = one holder active)
//   idx_width() : index width for n requesters; never returns 0, so a degenerate
//                 single-requester instance still elaborates with a 1-bit index.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req   : packed request vector, bit i = requester i
//   ptr   : index where the ascending scan starts (wraps M-1 -> 0)
//   found : at least one request is present
//   idx   : first requesting index at or after ptr (0 when nothing is found)
module rr_pick
  import arb_pkg::*;
#(
  parameter int M  = 4,
  parameter int IW = idx_width(M)
) (
  input  logic [M-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int pos;
    logic [IW-1:0] pos_idx;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < M; k++) begin
      // ptr + k, folded back into 0..M-1 without a modulo operator
      pos = int'(ptr) + k;
      if (pos >= M) begin
        pos = pos - M;
      end
      pos_idx = IW'(pos);
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/rr_unpacked_arbiter.sv
// Round-robin arbiter with bounded tenure, unpacked one-hot grant output.
//   clock    : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   enable   : permits new grants; an ongoing tenure always runs to its release
//   req      : packed request vector
//   grant    : registered one-hot (or all-zero) grant, unpacked [0:M-1]
//   grant_id : index of the holder; keeps its last value while not busy
//   busy     : OR of grant
module rr_unpacked_arbiter
  import arb_pkg::*;
#(
  parameter int  M       = 4,
  parameter int  MAXHOLD = 8,
  localparam int IW      = idx_width(M),
  localparam int CW      = $clog2(MAXHOLD + 1)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [M-1:0]  req,
  output logic          grant [0:M-1],
  output logic [IW-1:0] grant_id,
  output logic          busy
);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] ptr_reg,   ptr_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [IW-1:0] gid_reg,   gid_next;
  logic [M-1:0]  gnt_reg,   gnt_next;

  logic          holder_req;
  logic          at_max;
  logic          release_now;
  logic [IW-1:0] ptr_after;
  logic [IW-1:0] pick_ptr;
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  // Release decision for the current holder. On release the scan must already
  // start one past the holder in this same cycle, so the picker sees the
  // post-release pointer rather than ptr_reg -- that is what makes the
  // handover bubble-free and still lets the holder win again if alone.
  assign holder_req  = req[gid_reg];
  assign at_max      = (cnt_reg == CW'(MAXHOLD));
  assign release_now = (state_reg == GRANT) && (!holder_req || at_max);
  assign ptr_after   = (gid_reg == IW'(M - 1)) ? '0 : gid_reg + IW'(1);
  assign pick_ptr    = release_now ? ptr_after : ptr_reg;

  rr_pick #(
    .M  (M),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gid_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gid_reg   <= gid_next;
      gnt_reg   <= gnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gid_next   = gid_reg;
    gnt_next   = gnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (enable && pick_found) begin
          state_next         = GRANT;
          gid_next           = pick_idx;
          gnt_next           = '0;
          gnt_next[pick_idx] = 1'b1;
          cnt_next           = CW'(1);
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_next = cnt_reg + CW'(1);
        end else begin
          ptr_next = ptr_after;
          if (enable && pick_found) begin
            gid_next           = pick_idx;
            gnt_next           = '0;
            gnt_next[pick_idx] = 1'b1;
            cnt_next           = CW'(1);
          end else begin
            // grant_id deliberately left untouched: it keeps the last holder
            state_next = IDLE;
            gnt_next   = '0;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // Outputs: straight from registers, no path from req/enable
  always_comb begin
    for (int i = 0; i < M; i++) begin
      grant[i] = gnt_reg[i];
    end
    busy     = |gnt_reg;
    grant_id = gid_reg;
  end

endmodule

// File: tb/tb_rr_unpacked_arbiter.sv
module tb_rr_unpacked_arbiter;

  localparam int M       = 4;
  localparam int MAXHOLD = 8;
  localparam int IW      = 2;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          enable = 1'b0;
  logic [M-1:0]  req    = '0;
  logic          grant [0:M-1];
  logic [IW-1:0] grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the resource, for how many cycles so far,
  // where the next scan starts, and the last granted index.
  int m_holder = -1;
  int m_len    = 0;
  int m_ptr    = 0;
  int m_gid    = 0;

  always #5 clk = ~clk;

  rr_unpacked_arbiter #(
    .M       (M),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .clock    (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  function automatic int scan_from(input int start, input logic [M-1:0] r);
    for (int k = 0; k < M; k++) begin
      if (r[(start + k) % M]) return (start + k) % M;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_len    = 0;
    m_ptr    = 0;
    m_gid    = 0;
  endtask

  task automatic model_step(input logic [M-1:0] r, input logic en);
    int w;
    if (m_holder >= 0 && r[m_holder] && m_len < MAXHOLD) begin
      m_len++;
      return;
    end
    if (m_holder >= 0) m_ptr = (m_holder + 1) % M;
    w = scan_from(m_ptr, r);
    if (en && w >= 0) begin
      m_holder = w;
      m_len    = 1;
      m_gid    = w;
    end else begin
      m_holder = -1;
      m_len    = 0;
    end
  endtask

  function automatic logic [M-1:0] grant_vec();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = grant[i];
    return v;
  endfunction

  task automatic check_model(input string tag);
    logic [M-1:0] exp_v;
    logic [M-1:0] obs_v;
    exp_v = '0;
    if (m_holder >= 0) exp_v[m_holder] = 1'b1;
    obs_v = grant_vec();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s grant: got %b expected %b", tag, obs_v, exp_v);
    end
    checks++;
    assert (busy === (m_holder >= 0)) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, (m_holder >= 0));
    end
    checks++;
    assert (grant_id === IW'(m_gid)) else begin
      errors++;
      $error("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, m_gid);
    end
    $display("[%0t] %s req=%b en=%b grant=%b id=%0d busy=%b",
             $time, tag, req, enable, obs_v, grant_id, busy);
  endtask

  // Spec-derived constant expectation for a specific holder.
  task automatic expect_holder(input string tag, input int h);
    logic [M-1:0] exp_v;
    exp_v    = '0;
    exp_v[h] = 1'b1;
    checks++;
    assert (grant_vec() === exp_v && grant_id === IW'(h) && busy === 1'b1) else begin
      errors++;
      $error("FAIL %s holder: got grant=%b id=%0d busy=%b expected grant=%b id=%0d busy=1",
             tag, grant_vec(), grant_id, busy, exp_v, h);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step(req, enable);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("reset_async");
    checks++;
    assert (grant_vec() === '0 && busy === 1'b0 && grant_id === '0) else begin
      errors++;
      $error("FAIL reset_const: got grant=%b busy=%b id=%0d expected grant=0000 busy=0 id=0",
             grant_vec(), busy, grant_id);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [M-1:0] r;

    // Initial reset
    #1;
    do_reset();

    // First grant: single requester 2, one-edge latency
    enable = 1'b1;
    req    = 4'b0100;
    tick("first_grant");
    expect_holder("first_grant", 2);
    req = 4'b0000;
    tick("first_drop");

    // All requesting: rotation 0,1,2,3,0 with exactly MAXHOLD cycles each
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5 * MAXHOLD; k++) begin
      tick("rotate");
      expect_holder("rotate", (k / MAXHOLD) % M);
    end
    req = 4'b0000;
    tick("rotate_end");

    // Voluntary release by holder 1 after 3 cycles, requester 3 waiting
    do_reset();
    req = 4'b0010;
    tick("vol_hold");
    expect_holder("vol_hold", 1);
    req = 4'b1010;
    tick("vol_hold");
    tick("vol_hold");
    expect_holder("vol_hold3", 1);
    req = 4'b1000;
    tick("vol_handover");
    expect_holder("vol_handover", 3);
    req = 4'b0000;
    tick("vol_end");

    // Lone requester 2 for 20 cycles: forced releases re-grant it seamlessly
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick("lone");
      expect_holder("lone", 2);
    end
    req = 4'b0000;
    tick("lone_end");

    // enable dropped mid-tenure: holder finishes, then idle
    req    = 4'b1111;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) tick("en_hold");
    enable = 1'b0;
    for (int k = 0; k < 10; k++) tick("en_low");
    checks++;
    assert (busy === 1'b0 && grant_vec() === '0) else begin
      errors++;
      $error("FAIL en_low_idle: got busy=%b grant=%b expected busy=0 grant=0000",
             busy, grant_vec());
    end
    enable = 1'b1;

    // Reset mid-tenure, then the scan restarts at index 0
    req = 4'b1111;
    for (int k = 0; k < 3; k++) tick("pre_reset");
    do_reset();
    req = 4'b1010;
    tick("post_reset");
    expect_holder("post_reset", 1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = M'($urandom_range(0, 15));
      if (m_holder >= 0 && $urandom_range(0, 99) < 75) r[m_holder] = 1'b1;
      req    = r;
      enable = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_unpacked_arbiter.md
# rr_unpacked_arbiter

Round-robin arbiter that shares one downstream resource among M requesters. Takes packed request vector, returns registered one-hot grant as unpacked array `[0:M-1]`, matching the packed-in/unpacked-out port style of the datapath blocks it fronts. Sits between request sources and the shared resource; bounded hold time guarantees fairness. Serves as a TMR test vehicle for unpacked-array output ports with sequential state.

## Interface
- `M`, default 4: number of requesters, legal 2..16.
- `MAXHOLD`, default 8: max consecutive grant cycles per tenure, legal 1..255.
- `clock`  input  1: sole clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `enable`  input  1: permits new grants; does not cut an existing tenure.
- `req`  input  [M-1:0]: packed request vector, bit i = requester i.
- `grant`  output  logic unpacked [0:M-1]: registered grant, one-hot or all-zero.
- `grant_id`  output  [$clog2(M)-1:0]: index of granted requester; valid while `busy`.
- `busy`  output  1: high while any grant element is high.

## Operation
- State machine, states IDLE and GRANT; internal rotating pointer `ptr` (0..M-1) and hold counter `cnt`, width $clog2(MAXHOLD+1).
- Winner selection: first i with `req[i]`=1, scanning ascending from `ptr`, wrapping M-1 -> 0.
- IDLE: if `enable` and `|req`, load winner into `grant_id`, set `grant[winner]`, `cnt`<=1, go GRANT. Otherwise stay; outputs zero.
- GRANT, per cycle with holder h:
  - `req[h]`=1 and `cnt`<MAXHOLD: hold, `cnt`++.
  - `req[h]`=0 (voluntary release) or `cnt`==MAXHOLD (forced release): `ptr`<=(h+1) mod M, then re-arbitrate in the same edge using the new pointer and the current `req`, including h.
    - Winner found and `enable`: grant it, `cnt`<=1, stay GRANT. Zero-bubble handover.
    - Otherwise: clear grant, go IDLE.
  - Forced release with only h requesting: h is re-granted and `cnt` restarts at 1.
- `enable` low during GRANT: current tenure runs to release; no re-grant; then IDLE.
- Invariants: at most one `grant` element high; `busy` = OR of `grant`; `grant_id` retains its last value when not busy.
- Reset: `grant` all 0, `grant_id` 0, `busy` 0, `ptr` 0, `cnt` 0, state IDLE. Reset assertion mid-tenure clears the grant immediately (asynchronous). First grant after reset scans from index 0.

## Timing
- All outputs registered; no combinational path from `req`/`enable` to outputs.
- Latency: `req` sampled high at edge n -> `grant` high after edge n (visible cycle n+1).
- Voluntary release: `req[h]` low at edge n -> `grant[h]` low after edge n; next winner's grant high after the same edge.
- Max tenure: exactly MAXHOLD consecutive cycles of `grant[h]` before forced re-arbitration.
- Worst-case wait for a persistent requester: (M-1)*MAXHOLD cycles plus 1 cycle latency.
- Reset deassertion is synchronized externally; the block assumes a clean release relative to `clock`.

## Structure
- Package `arb_pkg`: state enum typedef `arb_state_t` {IDLE, GRANT}; localparam helper for the index width ($clog2 wrapper guarding M=1 misuse).
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs `req[M-1:0]`, `ptr`; outputs `found` and `idx`. Instantiated once by `rr_unpacked_arbiter`.
- Top holds the FSM, `ptr`, `cnt`, and the conversion of `idx` to the unpacked one-hot `grant`.

## Test plan
- Reset then M=4, `enable`=1, `req`=4'b0100 -> after 1 edge `grant`='{0,0,1,0}, `grant_id`=2, `busy`=1.
- `req`=4'b1111 held constant, MAXHOLD=8 -> grants rotate 0,1,2,3,0, each exactly 8 cycles, no idle gap.
- Holder 1 drops `req` after 3 cycles while `req[3]`=1 -> `grant[1]` low and `grant[3]` high after the same edge.
- Only requester 2 held 20 cycles, MAXHOLD=8 -> `grant[2]` continuously high; `cnt` restarts at cycles 9 and 17.
- `enable` low mid-tenure with others requesting -> holder keeps grant to release, then all-zero grant, `busy`=0.
- `rst_n` pulsed low mid-tenure -> `grant` all 0 immediately; after release `req`=4'b1010 grants index 1 first.
